// File: rtl/mips_pkg.sv
// ============================================================================
// Module : mips_pkg
// Brief  : Shared ALU opcode constants and multiply/divide FSM state type.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [5:0] OP_MFHI  = 6'h10;
    localparam logic [5:0] OP_MTHI  = 6'h11;
    localparam logic [5:0] OP_MFLO  = 6'h12;
    localparam logic [5:0] OP_MTLO  = 6'h13;
    localparam logic [5:0] OP_MULT  = 6'h18;
    localparam logic [5:0] OP_MULTU = 6'h19;
    localparam logic [5:0] OP_DIV   = 6'h1A;
    localparam logic [5:0] OP_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } mdu_state_t;

endpackage

`default_nettype wire

// File: rtl/mdu_div_step.sv
// ============================================================================
// Module : mdu_div_step
// Brief  : One restoring-divide step: shift in a dividend bit, trial-subtract
//          the divisor, keep or restore the partial remainder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_bit_i,
    input  logic [WIDTH-1:0] dvsr_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;

    // rem < divisor keeps the trial difference inside WIDTH+1 signed bits
    assign w_shift = {rem_i, dvd_bit_i};
    assign w_diff  = w_shift - {1'b0, dvsr_i};

    assign q_bit_o = ~w_diff[WIDTH];
    assign rem_o   = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/mdu_hilo.sv
// ============================================================================
// Module : mdu_hilo
// Brief  : Iterative multiply/divide unit owning the HI/LO registers.
//          Define MDU_FAST_MULT_EN for a single-cycle combinational multiply.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mdu_hilo
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [5:0]       alu_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    mdu_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, dvd_q, dvd_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               neg_q, neg_d, rneg_q, rneg_d, div_q, div_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               done_q, done_d;

    logic               w_signed, w_a_neg, w_b_neg, w_is_div;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_addend, w_rem_nxt, w_quo, w_rem;
    logic [WIDTH:0]     w_mul_sum;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_prod_mag, w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

    assign w_signed = (alu_op == OP_MULT) || (alu_op == OP_DIV);
    assign w_is_div = (alu_op == OP_DIV) || (alu_op == OP_DIVU);
    assign w_a_neg  = w_signed & rs_val[WIDTH-1];
    assign w_b_neg  = w_signed & rt_val[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -rs_val : rs_val;
    assign w_b_mag  = w_b_neg ? -rt_val : rt_val;

    // Multiply: upper half accumulates, lower half shifts the multiplier out
    assign w_addend  = p_q[0] ? a_q : '0;
    assign w_mul_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};

    mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (p_q[2*WIDTH-1:WIDTH]),
        .dvd_bit_i (p_q[WIDTH-1]),
        .dvsr_i    (b_q),
        .rem_o     (w_rem_nxt),
        .q_bit_o   (w_qbit)
    );

`ifdef MDU_FAST_MULT_EN
    assign w_prod_mag = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    assign busy       = (state_q == MUL) || (state_q == DIV) || ((state_q == FIN) && div_q);
`else
    assign w_prod_mag = p_q;
    assign busy       = (state_q != IDLE);
`endif

    assign w_prod_fix = neg_q ? -w_prod_mag : w_prod_mag;
    assign w_quo      = p_q[WIDTH-1:0];
    assign w_rem      = p_q[2*WIDTH-1:WIDTH];
    assign w_quo_fix  = neg_q  ? -w_quo : w_quo;
    assign w_rem_fix  = rneg_q ? -w_rem : w_rem;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        dvd_d   = dvd_q;
        p_d     = p_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div_d   = div_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    case (alu_op)
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            a_d    = w_a_mag;
                            b_d    = w_b_mag;
                            dvd_d  = rs_val;
                            neg_d  = w_a_neg ^ w_b_neg;
                            rneg_d = w_a_neg;
                            div_d  = w_is_div;
                            cnt_d  = '0;
                            p_d    = {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
`ifdef MDU_FAST_MULT_EN
                            state_d = w_is_div ? DIV : FIN;
`else
                            state_d = w_is_div ? DIV : MUL;
`endif
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                p_d   = {w_mul_sum, p_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST) state_d = FIN;
            end
            DIV: begin
                p_d   = {w_rem_nxt, p_q[WIDTH-2:0], w_qbit};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST) state_d = FIN;
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (!div_q) begin
                    {hi_d, lo_d} = w_prod_fix;
                end else if (b_q == '0) begin
                    // Divide by zero reports the untouched dividend in HI
                    lo_d = '1;
                    hi_d = dvd_q;
                end else begin
                    lo_d = w_quo_fix;
                    hi_d = w_rem_fix;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            dvd_q   <= '0;
            p_q     <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            dvd_q   <= dvd_d;
            p_q     <= p_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            div_q   <= div_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_hilo.sv
// ============================================================================
// Module : tb_mdu_hilo
// Brief  : Directed-vector bench for mdu_hilo (latency, results, corner cases).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mdu_hilo;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  alu_op = 6'h00;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    mdu_hilo #(.WIDTH(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .alu_op (alu_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ehi;
        logic [31:0] elo;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic run_op(input string nm, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int          lat;
        int          exp_lat;
        logic        exp_busy;
        logic [31:0] prev_hi;
        exp_lat  = 33;
        exp_busy = 1'b1;
`ifdef MDU_FAST_MULT_EN
        if (op == OP_MULT || op == OP_MULTU) begin
            exp_lat  = 1;
            exp_busy = 1'b0;
        end
`endif
        prev_hi = hi;
        @(negedge clk);
        start = 1'b1; alu_op = op; rs_val = a; rt_val = b;
        @(posedge clk);
        #1 start = 1'b0; alu_op = 6'h00;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                check({nm, "_busy_e1"}, {31'b0, busy}, {31'b0, exp_busy});
                if (exp_busy) check({nm, "_hi_hold"}, hi, prev_hi);
            end
            if (done) begin
                lat = c;
                break;
            end
        end
        check({nm, "_latency"}, lat, exp_lat);
        check({nm, "_busy_done"}, {31'b0, busy}, 32'd0);
        check({nm, "_hi"}, hi, ehi);
        check({nm, "_lo"}, lo, elo);
        @(posedge clk);
        #1 check({nm, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin : main
        int lat;
        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[4]  = '{OP_DIVU,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
        vecs[5]  = '{OP_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF};
        vecs[6]  = '{OP_DIVU,  32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999};
        vecs[7]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[9]  = '{OP_MULTU, 32'h12345678, 32'd16,       32'h00000001, 32'h23456780};
        vecs[10] = '{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001};

        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);

        // mthi then mtlo on consecutive edges
        start = 1'b1; alu_op = OP_MTHI; rs_val = 32'h1234;
        @(posedge clk);
        #1 check("mthi_hi", hi, 32'h1234);
        check("mthi_done", {31'b0, done}, 32'd0);
        alu_op = OP_MTLO; rs_val = 32'h5678;
        @(posedge clk);
        #1 check("mtlo_lo", lo, 32'h5678);
        check("mtlo_hi", hi, 32'h1234);
        check("mtlo_done", {31'b0, done}, 32'd0);
        check("mtlo_busy", {31'b0, busy}, 32'd0);
        alu_op = 6'h20; rs_val = 32'hDEADBEEF;
        @(posedge clk);
        #1 start = 1'b0;
        check("unrec_hi", hi, 32'h1234);
        check("unrec_lo", lo, 32'h5678);
        check("unrec_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1 check("unrec_done", {31'b0, done}, 32'd0);

        for (int i = 0; i < 11; i++)
            run_op($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo);

        // divu request while a divide is in flight is dropped
        @(negedge clk);
        start = 1'b1; alu_op = OP_DIVU; rs_val = 32'd100; rt_val = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; alu_op = OP_DIVU; rs_val = 32'd1000; rt_val = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 0;
        for (int c = 6; c <= 45; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
        check("ign_latency", lat, 32'd33);
        check("ign_lo", lo, 32'd14);
        check("ign_hi", hi, 32'd2);
        lat = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done) lat = lat + 1;
        end
        check("ign_no_second_done", lat, 32'd0);
        check("ign_lo_final", lo, 32'd14);

        // asynchronous reset at iteration 10 of a signed multiply
        @(negedge clk);
        start = 1'b1; alu_op = OP_MULT; rs_val = 32'd5; rt_val = 32'hFFFFFFF7;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mrst_hi", hi, 32'd0);
        check("mrst_lo", lo, 32'd0);
        check("mrst_busy", {31'b0, busy}, 32'd0);
        check("mrst_done", {31'b0, done}, 32'd0);
        @(negedge clk) rst = 1'b0;
        run_op("post_rst", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
